scope_sample_decimator: RTL and testbench

//  Fast-domain front stage of the scope capture path. It takes raw ADC samples at the sample-clock

---
 rtl/scope_sample_decimator.sv | 111 +++++++++++
 tb/tb_scope_sample_decimator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/scope_sample_decimator.sv
// rtl/scope_sample_decimator.sv - box-car decimator with held output and rising-edge trigger flag
// Optional window-maximum output is enabled by defining PEAK_DETECT_EN.
module scope_sample_decimator #(
    parameter int N            = 12,
    parameter int DEC_MAX_LOG2 = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sample_in,
    input  logic         sample_valid,
    input  logic [3:0]   dec_log2,
    input  logic [N-1:0] trig_level,
    input  logic         peak_mode,
    output logic [N-1:0] data_out,
    output logic         data_strobe,
    output logic         trig_hit
);

    localparam int         ACCW    = N + DEC_MAX_LOG2;
    localparam int         CW      = DEC_MAX_LOG2;
    localparam logic [3:0] DEC_MAX = DEC_MAX_LOG2[3:0];

    logic [3:0]      dec_q;
    logic [3:0]      dec_clamp;
    logic            dec_change;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] acc_sum;
    logic [ACCW-1:0] acc_shifted;
    logic [CW-1:0]   count;
    logic [CW-1:0]   last_count;
    logic            win_end;
    logic            prev_valid;
    logic [N-1:0]    mean;
    logic [N-1:0]    result;
    logic            rising;

    always_comb begin
        dec_clamp   = (dec_log2 > DEC_MAX) ? DEC_MAX : dec_log2;
        dec_change  = (dec_clamp != dec_q);
        last_count  = ~({CW{1'b1}} << dec_q);
        win_end     = sample_valid && (count == last_count);
        acc_sum     = acc + {{DEC_MAX_LOG2{1'b0}}, sample_in};
        acc_shifted = acc_sum >> dec_q;
        mean        = acc_shifted[N-1:0];
    end

`ifdef PEAK_DETECT_EN
    logic [N-1:0] peak;
    logic [N-1:0] peak_next;

    always_comb begin
        peak_next = (sample_in > peak) ? sample_in : peak;
        result    = peak_mode ? peak_next : mean;
    end

    // Peak restarts with each window, so a zero start value is the neutral element of max().
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak <= '0;
        end else if (dec_change) begin
            peak <= '0;
        end else if (sample_valid) begin
            peak <= win_end ? '0 : peak_next;
        end
    end
`else
    // peak_mode has no effect without the peak logic; the mux collapses to the mean.
    always_comb begin
        result = peak_mode ? mean : mean;
    end
`endif

    // data_out still holds the previous output here, so it serves as the trigger's "prev" value.
    always_comb begin
        rising = prev_valid && (data_out < trig_level) && (result >= trig_level);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q       <= '0;
            acc         <= '0;
            count       <= '0;
            prev_valid  <= 1'b0;
            data_out    <= '0;
            data_strobe <= 1'b0;
            trig_hit    <= 1'b0;
        end else begin
            data_strobe <= 1'b0;
            trig_hit    <= 1'b0;
            if (dec_change) begin
                dec_q      <= dec_clamp;
                acc        <= '0;
                count      <= '0;
                prev_valid <= 1'b0;
            end else if (sample_valid) begin
                if (win_end) begin
                    acc         <= '0;
                    count       <= '0;
                    data_out    <= result;
                    data_strobe <= 1'b1;
                    trig_hit    <= rising;
                    prev_valid  <= 1'b1;
                end else begin
                    acc   <= acc_sum;
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_scope_sample_decimator.sv
// tb/tb_scope_sample_decimator.sv - scoreboard bench for scope_sample_decimator
module tb_scope_sample_decimator;

    logic        clk;
    logic        rst_n;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic [3:0]  dec_log2;
    logic [11:0] trig_level;
    logic        peak_mode;
    logic [11:0] data_out;
    logic        data_strobe;
    logic        trig_hit;

    int checks   = 0;
    int failures = 0;
    logic [12:0] exp_q[$];

    scope_sample_decimator #(.N(12), .DEC_MAX_LOG2(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .dec_log2     (dec_log2),
        .trig_level   (trig_level),
        .peak_mode    (peak_mode),
        .data_out     (data_out),
        .data_strobe  (data_strobe),
        .trig_hit     (trig_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] s);
        sample_valid = v;
        sample_in    = s;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_exp(input logic [11:0] s, input logic [11:0] d, input logic t);
        exp_q.push_back({t, d});
        drive(1'b1, s);
        chk("strobe_latency", {31'd0, data_strobe}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (data_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", {31'd0, data_strobe}, 32'd0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    chk("data_out", {20'd0, data_out}, {20'd0, e[11:0]});
                    chk("trig_hit", {31'd0, trig_hit}, {31'd0, e[12]});
                end
            end else begin
                chk("trig_without_strobe", {31'd0, trig_hit}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] exp6;
        logic [11:0] s;
        logic [11:0] d;
        logic [11:0] prev;
        logic        pv;
        logic        t;
        int          sum;

        rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
        dec_log2 = 4'd0; trig_level = 12'd0; peak_mode = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_data_out", {20'd0, data_out}, 32'd0);
        chk("reset_strobe", {31'd0, data_strobe}, 32'd0);
        chk("reset_trig", {31'd0, trig_hit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // pass-through
        drive_exp(12'h123, 12'h123, 1'b0);
        drive_exp(12'h456, 12'h456, 1'b0);
        drive_exp(12'hFFF, 12'hFFF, 1'b0);

        // reset mid-window with a nonzero accumulator
        dec_log2 = 4'd2;
        drive(1'b1, 12'h777);
        drive(1'b1, 12'd100);
        drive(1'b1, 12'd200);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_data_out", {20'd0, data_out}, 32'd0);
        chk("midreset_strobe", {31'd0, data_strobe}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 12'd0);
        drive(1'b1, 12'd1);
        drive(1'b1, 12'd2);
        drive(1'b1, 12'd3);
        drive_exp(12'd4, 12'd2, 1'b0);

        // average with idle gaps
        drive(1'b1, 12'd10);
        drive(1'b0, 12'd0);
        drive(1'b1, 12'd20);
        drive(1'b0, 12'd0);
        drive(1'b0, 12'd0);
        drive(1'b1, 12'd30);
        drive(1'b0, 12'd0);
        drive_exp(12'd41, 12'd25, 1'b0);
        repeat (5) drive(1'b0, 12'hABC);
        chk("hold_data_out", {20'd0, data_out}, 32'd25);

        // clamped exponent, full-scale window
        dec_log2 = 4'd15;
        drive(1'b1, 12'hFFF);
        for (int i = 0; i < 255; i++) drive(1'b1, 12'hFFF);
        drive_exp(12'hFFF, 12'hFFF, 1'b0);

        // trigger crossings
        dec_log2 = 4'd0;
        trig_level = 12'h800;
        drive(1'b0, 12'd0);
        drive_exp(12'h7FF, 12'h7FF, 1'b0);
        drive_exp(12'h800, 12'h800, 1'b1);
        drive_exp(12'h900, 12'h900, 1'b0);
        drive_exp(12'h7FF, 12'h7FF, 1'b0);
        drive_exp(12'h800, 12'h800, 1'b1);
        drive_exp(12'h001, 12'h001, 1'b0);

        // ratio change mid-window; prev=1 < level=4 would fire if prev_valid survived
        trig_level = 12'd4;
        peak_mode  = 1'b1;
        dec_log2   = 4'd1;
        drive(1'b0, 12'd0);
        drive(1'b1, 12'h100);
        dec_log2 = 4'd2;
        drive(1'b1, 12'h200);
        drive(1'b1, 12'd5);
        drive(1'b1, 12'd9);
        drive(1'b1, 12'd2);
`ifdef PEAK_DETECT_EN
        exp6 = 12'd9;
`else
        exp6 = 12'd5;
`endif
        drive_exp(12'd7, exp6, 1'b0);

        // randomized windows against a reference model
        peak_mode  = 1'b0;
        dec_log2   = 4'd3;
        trig_level = 12'($urandom_range(1500, 2600));
        drive(1'b0, 12'd0);
        pv   = 1'b0;
        prev = 12'd0;
        for (int w = 0; w < 6; w++) begin
            sum = 0;
            for (int k = 0; k < 8; k++) begin
                repeat ($urandom_range(0, 2)) drive(1'b0, 12'($urandom));
                s = 12'($urandom_range(0, 4095));
                sum += int'(s);
                if (k < 7) begin
                    drive(1'b1, s);
                end else begin
                    d = 12'(sum >> 3);
                    t = pv && (prev < trig_level) && (d >= trig_level);
                    drive_exp(s, d, t);
                    prev = d;
                    pv   = 1'b1;
                end
            end
        end

        repeat (3) drive(1'b0, 12'd0);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
